// File: rtl/parity_frame_scheduler_if.sv
// Handshake bundle between the two byte requesters, the parity scheduler and the
// parity output consumer. The scheduler uses the slave view; drivers/consumers use master.
interface parity_frame_scheduler_if #(
  parameter int LEN_W = 4
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [15:0]      req_d;
  logic [15:0]      req_en;
  logic [1:0]       req_last;
  logic             out_valid;
  logic             out_ready;
  logic [8:0]       out_dp;
  logic             out_src;
  logic [LEN_W-1:0] out_idx;
  logic             out_last;
  logic             out_fpar;
  logic             out_ovf;

  modport slave (
    input  req_valid, req_d, req_en, req_last, out_ready,
    output req_ready, out_valid, out_dp, out_src, out_idx, out_last, out_fpar, out_ovf
  );

  modport master (
    output req_valid, req_d, req_en, req_last, out_ready,
    input  req_ready, out_valid, out_dp, out_src, out_idx, out_last, out_fpar, out_ovf
  );
endinterface

// File: rtl/parity_frame_scheduler.sv
// Round-robin two-requester frame scheduler feeding one shared even-parity byte
// unit; the grant is held for a whole frame and results leave on a registered stream.
module parity_frame_scheduler #(
  parameter int LEN_W = 4
) (
  input logic                    clk,
  input logic                    rst,
  parity_frame_scheduler_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             ptr_q, ptr_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic             facc_q, facc_d;
  logic             out_valid_q, out_valid_d;
  logic [8:0]       out_dp_q, out_dp_d;
  logic             out_src_q, out_src_d;
  logic [LEN_W-1:0] out_idx_q, out_idx_d;
  logic             out_last_q, out_last_d;
  logic             out_fpar_q, out_fpar_d;
  logic             out_ovf_q, out_ovf_d;

  logic [7:0] sel_d;
  logic [7:0] sel_en;
  logic       par;
  logic       at_max;
  logic       last_beat;
  logic       can_take;
  logic       accept;
  logic [1:0] req_ready;

  // Granted lane select, parity and the accept condition shared by both comb processes.
  always_comb begin
    sel_d     = gnt_q ? bus.req_d[15:8]  : bus.req_d[7:0];
    sel_en    = gnt_q ? bus.req_en[15:8] : bus.req_en[7:0];
    par       = ^(sel_d & sel_en);
    at_max    = (idx_q == {LEN_W{1'b1}});
    last_beat = bus.req_last[gnt_q] | at_max;
    can_take  = (state_q == BUSY) & (~out_valid_q | bus.out_ready);
    req_ready = 2'b00;
    req_ready[gnt_q] = can_take;
    accept    = bus.req_valid[gnt_q] & can_take;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|bus.req_valid) state_d = BUSY;
      BUSY:    if (accept && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    facc_d      = facc_q;
    out_valid_d = out_valid_q & ~bus.out_ready;
    out_dp_d    = out_dp_q;
    out_src_d   = out_src_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    out_fpar_d  = out_fpar_q;
    out_ovf_d   = out_ovf_q;
    if (state_q == IDLE && |bus.req_valid) begin
      gnt_d = bus.req_valid[ptr_q] ? ptr_q : ~ptr_q;
    end
    if (accept) begin
      out_valid_d = 1'b1;
      out_dp_d    = {par, sel_d};
      out_src_d   = gnt_q;
      out_idx_d   = idx_q;
      out_last_d  = last_beat;
      out_fpar_d  = facc_q ^ par;
      out_ovf_d   = ~bus.req_last[gnt_q] & at_max;
      // A closing beat, requested or forced by length, hands priority to the other side.
      if (last_beat) begin
        idx_d  = '0;
        facc_d = 1'b0;
        ptr_d  = ~gnt_q;
      end else begin
        idx_d  = idx_q + LEN_W'(1);
        facc_d = facc_q ^ par;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      ptr_q       <= 1'b0;
      idx_q       <= '0;
      facc_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_dp_q    <= '0;
      out_src_q   <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_fpar_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      facc_q      <= facc_d;
      out_valid_q <= out_valid_d;
      out_dp_q    <= out_dp_d;
      out_src_q   <= out_src_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_fpar_q  <= out_fpar_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_dp    = out_dp_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_fpar  = out_fpar_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule
